// File: rtl/ascon_pkg.sv
// Shared Ascon types and helpers: 320-bit state, sequencer FSM states,
// round-count limit and round-constant generation.
package ascon_pkg;

  localparam int MAX_ROUNDS = 12;

  typedef struct packed {
    logic [63:0] x0;
    logic [63:0] x1;
    logic [63:0] x2;
    logic [63:0] x3;
    logic [63:0] x4;
  } state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_state_e;

  // Upper nibble counts down while the lower nibble counts up.
  function automatic logic [63:0] rc(input logic [3:0] i);
    return {56'h0, 4'hF - i, i};
  endfunction

  function automatic logic [63:0] ror64(input logic [63:0] v, input int unsigned n);
    return (v >> n) | (v << (64 - n));
  endfunction

endpackage

// File: rtl/ascon_permutation_1p.sv
// One Ascon round: constant addition, bitsliced 5-bit S-box and linear diffusion layer.
module ascon_permutation_1p
  import ascon_pkg::*;
(
  input  state_t      state_i,
  input  logic [63:0] round_const,
  output state_t      state_o
);

  logic [63:0] a0, a1, a2, a3, a4;
  logic [63:0] t0, t1, t2, t3, t4;
  logic [63:0] b0, b1, b2, b3, b4;
  logic [63:0] c0, c1, c2, c3, c4;

  // Constant lands in x2 and is folded into the S-box input mixing.
  assign a0 = state_i.x0 ^ state_i.x4;
  assign a1 = state_i.x1;
  assign a2 = state_i.x2 ^ round_const ^ state_i.x1;
  assign a3 = state_i.x3;
  assign a4 = state_i.x4 ^ state_i.x3;

  assign t0 = ~a0 & a1;
  assign t1 = ~a1 & a2;
  assign t2 = ~a2 & a3;
  assign t3 = ~a3 & a4;
  assign t4 = ~a4 & a0;

  assign b0 = a0 ^ t1;
  assign b1 = a1 ^ t2;
  assign b2 = a2 ^ t3;
  assign b3 = a3 ^ t4;
  assign b4 = a4 ^ t0;

  assign c0 = b0 ^ b4;
  assign c1 = b1 ^ b0;
  assign c2 = ~b2;
  assign c3 = b3 ^ b2;
  assign c4 = b4;

  assign state_o.x0 = c0 ^ ror64(c0, 19) ^ ror64(c0, 28);
  assign state_o.x1 = c1 ^ ror64(c1, 61) ^ ror64(c1, 39);
  assign state_o.x2 = c2 ^ ror64(c2, 1)  ^ ror64(c2, 6);
  assign state_o.x3 = c3 ^ ror64(c3, 10) ^ ror64(c3, 17);
  assign state_o.x4 = c4 ^ ror64(c4, 7)  ^ ror64(c4, 41);

endmodule

// File: rtl/ascon_perm_ctrl.sv
// Iterative Ascon permutation sequencer running 1..MAX_ROUNDS rounds at one per clock.
// Define ASCON_PERM_CTRL_ABORT_EN to add the abort_i cancel input.
module ascon_perm_ctrl #(
  parameter int MAX_ROUNDS = ascon_pkg::MAX_ROUNDS,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [CNT_W-1:0] rounds_i,
  input  logic [63:0]      x0_i,
  input  logic [63:0]      x1_i,
  input  logic [63:0]      x2_i,
  input  logic [63:0]      x3_i,
  input  logic [63:0]      x4_i,
`ifdef ASCON_PERM_CTRL_ABORT_EN
  input  logic             abort_i,
`endif
  output logic             ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [63:0]      x0_o,
  output logic [63:0]      x1_o,
  output logic [63:0]      x2_o,
  output logic [63:0]      x3_o,
  output logic [63:0]      x4_o
);
  import ascon_pkg::*;

  localparam logic [CNT_W-1:0] MAX_R    = CNT_W'(MAX_ROUNDS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_ROUNDS - 1);

  fsm_state_e       state_q, state_n;
  logic [CNT_W-1:0] idx_q, idx_n, n_eff;
  state_t           st_q, st_n, st_load, st_round;
  logic [63:0]      round_const;
  logic             abort_req;

`ifdef ASCON_PERM_CTRL_ABORT_EN
  assign abort_req = abort_i;
`else
  assign abort_req = 1'b0;
`endif

  // Out-of-range round counts fall back to the full permutation.
  assign n_eff = (rounds_i == '0 || rounds_i > MAX_R) ? MAX_R : rounds_i;

  assign st_load     = '{x0: x0_i, x1: x1_i, x2: x2_i, x3: x3_i, x4: x4_i};
  assign round_const = rc(4'(idx_q));

  ascon_permutation_1p u_round (
    .state_i     (st_q),
    .round_const (round_const),
    .state_o     (st_round)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      st_q    <= '0;
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
      st_q    <= st_n;
    end
  end

  // Abort leaves the partially permuted state in place.
  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    st_n    = st_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          st_n    = st_load;
          idx_n   = MAX_R - n_eff;
          state_n = RUN;
        end else begin
          state_n = IDLE;
        end
      end
      RUN: begin
        if (abort_req) begin
          state_n = IDLE;
        end else begin
          st_n  = st_round;
          idx_n = idx_q + 1'b1;
          if (idx_q == LAST_IDX) state_n = DONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign ready_o = (state_q != RUN);
  assign busy_o  = (state_q == RUN);
  assign done_o  = (state_q == DONE);

  assign x0_o = st_q.x0;
  assign x1_o = st_q.x1;
  assign x2_o = st_q.x2;
  assign x3_o = st_q.x3;
  assign x4_o = st_q.x4;

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// Self-checking bench for ascon_perm_ctrl against a table-driven Ascon model.
// Abort scenario runs only when ASCON_PERM_CTRL_ABORT_EN is defined.
module tb_ascon_perm_ctrl;

  typedef logic [4:0][63:0] words_t;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic [3:0]  rounds_i;
  logic [63:0] x0_i, x1_i, x2_i, x3_i, x4_i;
`ifdef ASCON_PERM_CTRL_ABORT_EN
  logic        abort_i;
`endif
  logic        ready_o, busy_o, done_o;
  logic [63:0] x0_o, x1_o, x2_o, x3_o, x4_o;

  int total = 0;
  int bad   = 0;

  byte unsigned sbox [32] = '{
    8'h04, 8'h0b, 8'h1f, 8'h14, 8'h1a, 8'h15, 8'h09, 8'h02,
    8'h1b, 8'h05, 8'h08, 8'h12, 8'h1d, 8'h03, 8'h06, 8'h1c,
    8'h1e, 8'h13, 8'h07, 8'h0e, 8'h00, 8'h0d, 8'h11, 8'h18,
    8'h10, 8'h0c, 8'h01, 8'h19, 8'h16, 8'h0a, 8'h0f, 8'h17};
  int rot_a [5] = '{19, 61, 1, 10, 7};
  int rot_b [5] = '{28, 39, 6, 17, 41};

  ascon_perm_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .rounds_i (rounds_i),
    .x0_i     (x0_i),
    .x1_i     (x1_i),
    .x2_i     (x2_i),
    .x3_i     (x3_i),
    .x4_i     (x4_i),
`ifdef ASCON_PERM_CTRL_ABORT_EN
    .abort_i  (abort_i),
`endif
    .ready_o  (ready_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .x0_o     (x0_o),
    .x1_o     (x1_o),
    .x2_o     (x2_o),
    .x3_o     (x3_o),
    .x4_o     (x4_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [63:0] rotr(logic [63:0] v, int n);
    logic [127:0] d;
    d = {v, v} >> n;
    return d[63:0];
  endfunction

  // Column-wise S-box lookup over the 64 bit positions, then diffusion.
  function automatic words_t ref_perm(words_t w, int first, int count);
    words_t s;
    words_t t;
    logic [4:0] col;
    logic [7:0] sb;
    s = w;
    t = '0;
    for (int r = first; r < first + count; r++) begin
      s[2] = s[2] ^ 64'((15 - r) * 16 + r);
      for (int b = 0; b < 64; b++) begin
        col = {s[0][b], s[1][b], s[2][b], s[3][b], s[4][b]};
        sb  = sbox[col];
        for (int k = 0; k < 5; k++) t[k][b] = sb[4-k];
      end
      for (int k = 0; k < 5; k++) s[k] = t[k] ^ rotr(t[k], rot_a[k]) ^ rotr(t[k], rot_b[k]);
    end
    return s;
  endfunction

  function automatic logic [319:0] flat(words_t w);
    return {w[0], w[1], w[2], w[3], w[4]};
  endfunction

  function automatic words_t rand_words();
    words_t w;
    for (int k = 0; k < 5; k++) w[k] = {$urandom, $urandom};
    return w;
  endfunction

  function automatic int eff_rounds(int r);
    return (r == 0 || r > 12) ? 12 : r;
  endfunction

  task automatic checkOutput(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input words_t w, input int r);
    x0_i     = w[0];
    x1_i     = w[1];
    x2_i     = w[2];
    x3_i     = w[3];
    x4_i     = w[4];
    rounds_i = 4'(r);
    start_i  = 1'b1;
    @(posedge clk); #1;
    start_i  = 1'b0;
  endtask

  // Counts edges until done_o, optionally checking the per-round constant.
  task automatic waitDone(input int n, input int already, input bit chk_rc, output int cyc);
    int i;
    cyc = 0;
    while (done_o !== 1'b1 && cyc < 40) begin
      if (chk_rc && busy_o === 1'b1) begin
        i = 12 - n + already + cyc;
        checkOutput($sformatf("rc_n%0d_k%0d", n, already + cyc + 1),
                    320'(dut.round_const), 320'((15 - i) * 16 + i));
      end
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  function automatic logic [319:0] dut_state();
    return {x0_o, x1_o, x2_o, x3_o, x4_o};
  endfunction

  initial begin
    words_t w, w2;
    words_t exp_w;
    int cyc, cnt, rr;
    int rlist [4] = '{6, 0, 15, 12};

    rst_n = 1'b0; start_i = 1'b0; rounds_i = '0;
    x0_i = '0; x1_i = '0; x2_i = '0; x3_i = '0; x4_i = '0;
`ifdef ASCON_PERM_CTRL_ABORT_EN
    abort_i = 1'b0;
`endif
    #7;
    checkOutput("reset_ready", 320'(ready_o), 320'(1));
    checkOutput("reset_busy",  320'(busy_o),  320'(0));
    checkOutput("reset_done",  320'(done_o),  320'(0));
    checkOutput("reset_state", dut_state(), '0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] p12 on all-zero state");
    w = '0;
    applyStimulus(w, 12);
    checkOutput("p12_busy", 320'(busy_o), 320'(1));
    checkOutput("p12_ready_low", 320'(ready_o), 320'(0));
    waitDone(12, 0, 1'b1, cyc);
    checkOutput("p12_latency", 320'(cyc), 320'(12));
    exp_w = ref_perm(w, 0, 12);
    checkOutput("p12_result", dut_state(), flat(exp_w));
    checkOutput("p12_done_ready", 320'(ready_o), 320'(1));
    @(posedge clk); #1;
    checkOutput("p12_done_pulse", 320'(done_o), 320'(0));
    repeat (3) @(posedge clk);
    #1;
    checkOutput("p12_hold", dut_state(), flat(exp_w));

    $display("[TB] p8 on random state");
    w = rand_words();
    applyStimulus(w, 8);
    waitDone(8, 0, 1'b1, cyc);
    checkOutput("p8_latency", 320'(cyc), 320'(8));
    checkOutput("p8_result", dut_state(), flat(ref_perm(w, 4, 8)));
    @(posedge clk); #1;

    $display("[TB] round counts 6, 0, 15, 12");
    foreach (rlist[j]) begin
      rr = rlist[j];
      w = rand_words();
      applyStimulus(w, rr);
      waitDone(eff_rounds(rr), 0, 1'b1, cyc);
      checkOutput($sformatf("r%0d_latency", rr), 320'(cyc), 320'(eff_rounds(rr)));
      checkOutput($sformatf("r%0d_result", rr), dut_state(),
                  flat(ref_perm(w, 12 - eff_rounds(rr), eff_rounds(rr))));
      @(posedge clk); #1;
    end

    $display("[TB] start during RUN, then start in DONE");
    w  = rand_words();
    w2 = rand_words();
    applyStimulus(w, 4);
    @(posedge clk); #1;
    x0_i = w2[0]; x1_i = w2[1]; x2_i = w2[2]; x3_i = w2[3]; x4_i = w2[4];
    rounds_i = 4'd2;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    checkOutput("midrun_busy", 320'(busy_o), 320'(1));
    waitDone(4, 2, 1'b1, cyc);
    checkOutput("midrun_latency", 320'(cyc + 2), 320'(4));
    checkOutput("midrun_result", dut_state(), flat(ref_perm(w, 8, 4)));
    w2 = rand_words();
    applyStimulus(w2, 5);
    checkOutput("b2b_accepted", 320'(busy_o), 320'(1));
    waitDone(5, 0, 1'b0, cyc);
    checkOutput("b2b_spacing", 320'(cyc + 1), 320'(6));
    checkOutput("b2b_result", dut_state(), flat(ref_perm(w2, 7, 5)));
    @(posedge clk); #1;

    $display("[TB] reset during round 5 of 12");
    w = rand_words();
    applyStimulus(w, 12);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_busy",  320'(busy_o),  320'(0));
    checkOutput("rst_ready", 320'(ready_o), 320'(1));
    checkOutput("rst_done",  320'(done_o),  320'(0));
    checkOutput("rst_state", dut_state(), '0);
    #2 rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (done_o === 1'b1) cnt++;
    end
    checkOutput("rst_no_done", 320'(cnt), 320'(0));
    checkOutput("rst_state_idle", dut_state(), '0);

`ifdef ASCON_PERM_CTRL_ABORT_EN
    $display("[TB] abort at round 3");
    w = rand_words();
    applyStimulus(w, 12);
    repeat (2) @(posedge clk);
    #1;
    abort_i = 1'b1;
    @(posedge clk); #1;
    abort_i = 1'b0;
    checkOutput("abort_ready", 320'(ready_o), 320'(1));
    checkOutput("abort_busy",  320'(busy_o),  320'(0));
    checkOutput("abort_state", dut_state(), flat(ref_perm(w, 0, 2)));
    cnt = 0;
    for (int k = 0; k < 15; k++) begin
      if (done_o === 1'b1) cnt++;
      @(posedge clk); #1;
    end
    checkOutput("abort_no_done", 320'(cnt), 320'(0));
    w = rand_words();
    applyStimulus(w, 8);
    waitDone(8, 0, 1'b0, cyc);
    checkOutput("post_abort_latency", 320'(cyc), 320'(8));
    checkOutput("post_abort_result", dut_state(), flat(ref_perm(w, 4, 8)));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
